// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and SPI mode / edge-select helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoad     = 2'd1,
    StTransfer = 2'd2,
    StDone     = 2'd3
  } spi_state_e;

  localparam logic [1:0] SpiMode0 = 2'b00;
  localparam logic [1:0] SpiMode1 = 2'b01;
  localparam logic [1:0] SpiMode2 = 2'b10;
  localparam logic [1:0] SpiMode3 = 2'b11;

  // Modes 0 and 3 sample MOSI on the rising SCLK edge; modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    logic [1:0] mode;
    mode = {cpol, cpha};
    return (mode == SpiMode0) || (mode == SpiMode3);
  endfunction

  // Modes 1 and 2 shift (drive MISO) on the rising edge.
  function automatic logic shift_on_rise(input logic cpol, input logic cpha);
    logic [1:0] mode;
    mode = {cpol, cpha};
    return (mode == SpiMode1) || (mode == SpiMode2);
  endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins plus the transmit/receive word handshakes and status of spi_slave_param.
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              CPOL;
  logic              CPHA;
  logic              CS;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              rx_overrun;
  logic              tx_underrun;
  logic              frame_err;

  modport slave (
    input  CPOL, CPHA, CS, SCLK, MOSI, tx_data, tx_valid, rx_ready,
    output MISO, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err
  );

  modport master (
    output CPOL, CPHA, CS, SCLK, MOSI, tx_data, tx_valid, rx_ready,
    input  MISO, tx_ready, rx_data, rx_valid, busy, rx_overrun, tx_underrun, frame_err
  );

endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer bringing an asynchronous input into the clk domain.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, all modes, oversampled in the clk domain; word-wide tx/rx handshakes with
// a single tx holding register and overrun/underrun/frame error pulses.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  spi_slave_param_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Input synchronizers and edge detection
  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (bus.SCLK),
    .q     (sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .d     (bus.CS),
    .q     (cs_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (bus.MOSI),
    .q     (mosi_s)
  );

  logic sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall;

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign sample_edge = sample_on_rise(bus.CPOL, bus.CPHA) ? sclk_rise : sclk_fall;
  assign shift_edge  = shift_on_rise(bus.CPOL, bus.CPHA) ? sclk_rise : sclk_fall;
  assign cs_fall     = cs_q & ~cs_s;

  // State
  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;

  logic              drain, tx_ready, tx_accept;
  logic [DATA_W-1:0] load_word;

  assign drain     = (state_q == StLoad);
  assign tx_ready  = !hold_full_q || drain;
  assign tx_accept = bus.tx_valid && tx_ready;
  assign load_word = hold_full_q ? hold_q : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    // A word offered during the draining LOAD cycle lands in the freed register.
    if (tx_accept) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end

    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (cs_fall) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        underrun_d = !hold_full_q;
        cnt_d      = '0;
        if (!bus.CPHA) begin
          miso_d  = first_bit(load_word);
          tx_sh_d = shift_out(load_word);
        end else begin
          tx_sh_d = load_word;
        end
        state_d = StTransfer;
      end
      StTransfer: begin
        // With CPHA=0 a shift edge before the first sample is the previous word's tail.
        if (shift_edge && (bus.CPHA || (cnt_q != '0))) begin
          miso_d  = first_bit(tx_sh_q);
          tx_sh_d = shift_out(tx_sh_q);
        end
        if (sample_edge) begin
          rx_sh_d = shift_in(rx_sh_q, mosi_s);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LastBit) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
        overrun_d  = rx_valid_q && !bus.rx_ready;
        state_d    = StLoad;
      end
      default: state_d = StIdle;
    endcase

    if (cs_s) begin
      state_d     = StIdle;
      miso_d      = 1'b0;
      cnt_d       = '0;
      frame_err_d = (state_q == StTransfer) && (cnt_q != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q      <= 1'b0;
      cs_q        <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_s;
      cs_q        <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.MISO        = miso_q & ~cs_s;
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.rx_overrun  = overrun_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit MSB-first and a 16-bit LSB-first slave driven by a
// behavioural SPI master; expectations come from word-level transfer rules.
module tb_spi_slave_param;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset;
  logic cpol, cpha, sclk, mosi, cs8, cs16;

  always #5 clk = ~clk;

  spi_slave_param_if #(.DATA_W(8))  if8 ();
  spi_slave_param_if #(.DATA_W(16)) if16 ();

  assign if8.CPOL  = cpol;
  assign if8.CPHA  = cpha;
  assign if8.SCLK  = sclk;
  assign if8.MOSI  = mosi;
  assign if8.CS    = cs8;
  assign if16.CPOL = cpol;
  assign if16.CPHA = cpha;
  assign if16.SCLK = sclk;
  assign if16.MOSI = mosi;
  assign if16.CS   = cs16;

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor of the 8-bit slave: received-word log and error pulse counts.
  logic [31:0] rx_log[64];
  int rx_n  = 0;
  int ovr_n = 0;
  int udr_n = 0;
  int fer_n = 0;

  always @(posedge clk) begin
    if (if8.rx_valid && if8.rx_ready) begin
      rx_log[rx_n[5:0]] <= 32'(if8.rx_data);
      rx_n <= rx_n + 1;
    end
    if (if8.rx_overrun)  ovr_n <= ovr_n + 1;
    if (if8.tx_underrun) udr_n <= udr_n + 1;
    if (if8.frame_err)   fer_n <= fer_n + 1;
  end

  logic [31:0] m_tx[4];
  logic [31:0] m_rx[4];
  logic        first_miso;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int sel, input logic [31:0] word);
    int n;
    n = 0;
    if (sel == 0) begin
      if8.tx_data  = word[7:0];
      if8.tx_valid = 1'b1;
    end else begin
      if16.tx_data  = word[15:0];
      if16.tx_valid = 1'b1;
    end
    while (n < 4000) begin
      @(posedge clk);
      if ((sel == 0) ? if8.tx_ready : if16.tx_ready) break;
      n++;
    end
    #1;
    if8.tx_valid  = 1'b0;
    if16.tx_valid = 1'b0;
    check("tx_handshake_in_time", 32'(n < 4000), 32'd1);
  endtask

  // Behavioural master: nwords back-to-back words under one CS; stop_at>0 aborts early.
  task automatic spi_xfer(input int sel, input int nwords, input int nbits, input bit msb,
                          input int stop_at);
    int   total, w, b, bi;
    logic s;
    total = nwords * nbits;
    for (int k = 0; k < 4; k++) m_rx[k] = '0;
    sclk = cpol;
    tick(2);
    if (sel == 0) cs8 = 1'b0;
    else          cs16 = 1'b0;
    for (int i = 0; i < total; i++) begin
      w  = i / nbits;
      b  = i % nbits;
      bi = msb ? nbits - 1 - b : b;
      if (stop_at != 0 && i == stop_at) break;
      if (!cpha) begin
        mosi = m_tx[w][bi];
        tick(HALF);
        s    = (sel == 0) ? if8.MISO : if16.MISO;
        sclk = ~cpol;
      end else begin
        tick(HALF);
        sclk = ~cpol;
        mosi = m_tx[w][bi];
        tick(HALF);
        s    = (sel == 0) ? if8.MISO : if16.MISO;
        sclk = cpol;
      end
      m_rx[w][bi] = s;
      if (i == 0) first_miso = s;
      if (i == total - 1) begin
        tick(1);
        cs8  = 1'b1;
        cs16 = 1'b1;
      end
      if (!cpha) begin
        tick(HALF);
        sclk = cpol;
      end
    end
    tick(HALF);
    cs8  = 1'b1;
    cs16 = 1'b1;
    sclk = cpol;
    tick(2 * HALF);
  endtask

  initial begin
    int          base, o0, u0, f0, m;
    bit          pre;
    logic [31:0] txw, rxw, exp_miso;
    logic        keep_valid;
    logic [31:0] keep_data;

    reset = 1'b0;
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
    cs8 = 1'b1; cs16 = 1'b1;
    if8.tx_valid = 1'b0;  if8.tx_data = '0;  if8.rx_ready = 1'b0;
    if16.tx_valid = 1'b0; if16.tx_data = '0; if16.rx_ready = 1'b0;
    tick(3);
    check("rst_tx_ready", 32'(if8.tx_ready), 32'd1);
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_rx_valid", 32'(if8.rx_valid), 32'd0);
    check("rst_miso", 32'(if8.MISO), 32'd0);
    reset = 1'b1;
    tick(5);

    // Mode 0 basic transfer, rx_ready held low so the word stays presented
    preload(0, 32'hA5);
    m_tx[0] = 32'h3C;
    spi_xfer(0, 1, 8, 1'b1, 0);
    check("m0_master_rx", m_rx[0], 32'hA5);
    check("m0_rx_data", 32'(if8.rx_data), 32'h3C);
    check("m0_rx_valid", 32'(if8.rx_valid), 32'd1);
    check("m0_busy_after", 32'(if8.busy), 32'd0);
    if8.rx_ready = 1'b1;
    tick(2);

    // Modes 1..3
    for (int md = 1; md < 4; md++) begin
      cpol = md[1]; cpha = md[0];
      base = rx_n;
      preload(0, 32'h81);
      m_tx[0] = 32'h7E;
      spi_xfer(0, 1, 8, 1'b1, 0);
      check($sformatf("mode%0d_master_rx", md), m_rx[0], 32'h81);
      check($sformatf("mode%0d_rx_count", md), 32'(rx_n - base), 32'd1);
      check($sformatf("mode%0d_rx_word", md), rx_log[base[5:0]], 32'h7E);
      check($sformatf("mode%0d_miso_idle", md), 32'(if8.MISO), 32'd0);
    end

    // Mode 0 burst of three words, later words fed during the transfer
    cpol = 1'b0; cpha = 1'b0;
    base = rx_n; o0 = ovr_n; u0 = udr_n; f0 = fer_n;
    preload(0, 32'h11);
    m_tx[0] = 32'hA1; m_tx[1] = 32'hB2; m_tx[2] = 32'hC3;
    fork
      spi_xfer(0, 3, 8, 1'b1, 0);
      begin
        preload(0, 32'h22);
        preload(0, 32'h33);
      end
    join
    check("burst_miso0", m_rx[0], 32'h11);
    check("burst_miso1", m_rx[1], 32'h22);
    check("burst_miso2", m_rx[2], 32'h33);
    check("burst_rx_count", 32'(rx_n - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("burst_rx%0d", k), rx_log[6'(base + k)], m_tx[k]);
    end
    check("burst_errors", 32'((ovr_n - o0) + (udr_n - u0) + (fer_n - f0)), 32'd0);

    // Randomized single-word frames; an unloaded frame must return zeros with an underrun
    for (int it = 0; it < 8; it++) begin
      m    = int'($urandom_range(0, 3));
      cpol = m[1]; cpha = m[0];
      txw  = $urandom & 32'hFF;
      rxw  = $urandom & 32'hFF;
      pre  = ($urandom_range(0, 3) != 0);
      exp_miso = pre ? txw : 32'h0;
      base = rx_n; u0 = udr_n;
      if (pre) preload(0, txw);
      m_tx[0] = rxw;
      spi_xfer(0, 1, 8, 1'b1, 0);
      check($sformatf("rand%0d_m%0d_master_rx", it, m), m_rx[0], exp_miso);
      check($sformatf("rand%0d_rx_word", it), rx_log[base[5:0]], rxw);
      check($sformatf("rand%0d_underrun", it), 32'(udr_n - u0), 32'(!pre));
    end

    // Overrun: two words with nobody reading
    cpol = 1'b0; cpha = 1'b0;
    if8.rx_ready = 1'b0;
    tick(2);
    o0 = ovr_n;
    preload(0, 32'h44);
    m_tx[0] = 32'h01;
    spi_xfer(0, 1, 8, 1'b1, 0);
    preload(0, 32'h55);
    m_tx[0] = 32'h02;
    spi_xfer(0, 1, 8, 1'b1, 0);
    check("ovr_rx_data", 32'(if8.rx_data), 32'h02);
    check("ovr_rx_valid", 32'(if8.rx_valid), 32'd1);
    check("ovr_pulses", 32'(ovr_n - o0), 32'd1);

    // Empty holding register at CS fall
    u0 = udr_n;
    m_tx[0] = 32'h99;
    spi_xfer(0, 1, 8, 1'b1, 0);
    check("udr_master_rx", m_rx[0], 32'h00);
    check("udr_pulses", 32'(udr_n - u0), 32'd1);

    // Abort after 5 bits: partial word dropped, presented word untouched
    keep_valid = if8.rx_valid;
    keep_data  = 32'(if8.rx_data);
    f0 = fer_n;
    preload(0, 32'h3C);
    m_tx[0] = 32'hF0;
    spi_xfer(0, 1, 8, 1'b1, 5);
    check("ferr_pulses", 32'(fer_n - f0), 32'd1);
    check("ferr_rx_valid", 32'(if8.rx_valid), 32'(keep_valid));
    check("ferr_rx_data", 32'(if8.rx_data), keep_data);
    check("ferr_idle", 32'(if8.busy), 32'd0);
    if8.rx_ready = 1'b1;
    tick(2);
    base = rx_n;
    preload(0, 32'h66);
    m_tx[0] = 32'h5A;
    spi_xfer(0, 1, 8, 1'b1, 0);
    check("ferr_next_rx", rx_log[base[5:0]], 32'h5A);
    check("ferr_next_miso", m_rx[0], 32'h66);

    // 16-bit LSB-first slave
    preload(1, 32'h1234);
    m_tx[0] = 32'hBEEF;
    spi_xfer(1, 1, 16, 1'b0, 0);
    check("w16_first_miso", 32'(first_miso), 32'(1'b0));
    check("w16_master_rx", m_rx[0], 32'h1234);
    check("w16_rx_data", 32'(if16.rx_data), 32'hBEEF);
    check("w16_rx_valid", 32'(if16.rx_valid), 32'd1);

    // Reset in the middle of a frame
    if8.rx_ready = 1'b0;
    preload(0, 32'hC3);
    f0 = fer_n;
    sclk = 1'b0;
    cs8  = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(if8.busy), 32'd0);
    check("midrst_miso", 32'(if8.MISO), 32'd0);
    check("midrst_rx_data", 32'(if8.rx_data), 32'd0);
    check("midrst_rx_valid", 32'(if8.rx_valid), 32'd0);
    check("midrst_tx_ready", 32'(if8.tx_ready), 32'd1);
    check("midrst_rx_data16", 32'(if16.rx_data), 32'd0);
    tick(3);
    sclk  = 1'b0;
    reset = 1'b1;
    tick(10);
    check("midrst_wait_cs", 32'(if8.busy), 32'd0);
    check("midrst_no_ferr", 32'(fer_n - f0), 32'd0);
    cs8 = 1'b1;
    tick(10);
    if8.rx_ready = 1'b1;
    base = rx_n;
    preload(0, 32'h6B);
    m_tx[0] = 32'hD2;
    spi_xfer(0, 1, 8, 1'b1, 0);
    check("postrst_master_rx", m_rx[0], 32'h6B);
    check("postrst_rx_word", rx_log[base[5:0]], 32'hD2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word length in bits (legal values 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning shift order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning flop count of the input synchronizers (legal values 2..3).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have ports CPOL and CPHA, input, 1 each, SPI mode; both are static while CS is low.
REQ-007 SHALL have ports CS, SCLK and MOSI, input, 1 each: chip select (active low), SPI clock, master data out.
REQ-008 SHALL have port MISO, output, 1, slave data out.
REQ-009 SHALL have ports tx_data (input, DATA_W), tx_valid (input, 1) and tx_ready (output, 1), the transmit word handshake.
REQ-010 SHALL have ports rx_data (output, DATA_W), rx_valid (output, 1) and rx_ready (input, 1), the receive word handshake.
REQ-011 SHALL have ports busy, rx_overrun, tx_underrun and frame_err, output, 1 each: frame in progress, and three one-cycle error pulses.

Function
REQ-012 SHALL pass SCLK, CS and MOSI through SYNC_STAGES flops each and SHALL derive SCLK edges from the last synchronizer flop versus one further flop; no logic is clocked by SCLK. Requires f_clk >= 8 x f_SCLK.
REQ-013 SHALL sample MOSI on the rising SCLK edge when CPOL==CPHA, otherwise on the falling edge; the opposite edge is the shift edge.
REQ-014 SHALL implement states IDLE, LOAD, TRANSFER and DONE with these transitions:
- IDLE->LOAD on synced CS falling.
- LOAD->TRANSFER after exactly 1 cycle.
- TRANSFER->DONE on the DATA_W-th sample edge.
- DONE->LOAD if CS is still low (burst), else DONE->IDLE.
- Any state->IDLE on synced CS high.
REQ-015 In LOAD, SHALL copy the tx holding register into the shift register and mark the holding register empty; if the holding register is empty, SHALL load all-zeros and pulse tx_underrun.
REQ-016 When CPHA=0, SHALL drive the first bit on MISO at the end of LOAD; when CPHA=1, SHALL drive it at the first shift edge. Subsequent bits change only on shift edges.
REQ-017 SHALL drive MISO to 0 whenever synced CS is high.
REQ-018 SHALL use a bit counter of width $clog2(DATA_W+1) that is cleared in LOAD and increments on each sample edge in TRANSFER.
REQ-019 In DONE, SHALL copy the received word to rx_data and set rx_valid, which holds until a cycle with rx_ready=1.
- If rx_valid is still 1 at DONE, SHALL overwrite rx_data, keep rx_valid=1 and pulse rx_overrun.
- DONE and an rx_ready handshake in the same cycle: DONE wins, so rx_valid stays 1.
REQ-020 SHALL assert tx_ready=1 while the holding register is empty or is being drained in the current LOAD cycle. SHALL accept tx_data on tx_valid && tx_ready; a word accepted in the same cycle as a drain is kept.
REQ-021 If CS rises while the bit counter is between 1 and DATA_W-1, SHALL discard the partial word, leave rx_data/rx_valid unchanged, pulse frame_err and go to IDLE; the holding register is kept.
REQ-022 SHALL assert busy=1 in LOAD, TRANSFER and DONE, and busy=0 in IDLE.
REQ-023 SHALL restart the counter at 0 for each burst word; SCLK edges in IDLE are ignored.

Reset
REQ-024 When reset=0, SHALL asynchronously clear the following to 0: state (to IDLE), synchronizers, MISO, bit counter, shift registers, holding register, rx_data, rx_valid, busy and all error pulses. tx_ready SHALL be 1 in reset, since the holding register is empty.
REQ-025 Reset asserted mid-frame SHALL abort the frame without a frame_err pulse; after release the block waits for a fresh CS falling edge.

Structure
REQ-026 SHALL take the state encoding (IDLE=0, LOAD=1, TRANSFER=2, DONE=3) and the mode/edge-select helper constants from shared package spi_pkg.
REQ-027 SHALL instantiate sub-module spi_sync (parameter STAGES, 1-bit) once each for SCLK, CS and MOSI.

Verification
REQ-028 Mode 0, DATA_W=8, tx 0xA5 preloaded, master sends 0x3C -> master receives 0xA5; rx_data=0x3C; rx_valid rises 1 clk after DONE.
REQ-029 Modes 1, 2 and 3, each with tx 0x81 and rx 0x7E -> both directions correct in every mode; MISO=0 while CS is high.
REQ-030 Mode 0 burst of 3 words, tx 0x11, 0x22, 0x33 supplied via handshake, rx_ready=1 -> master receives 0x11 0x22 0x33; 3 rx_valid handshakes; no errors.
REQ-031 rx_ready=0 for two received words 0x01 then 0x02 -> rx_data=0x02; rx_overrun pulses once. Empty holding register at CS fall -> master receives 0x00; tx_underrun pulses.
REQ-032 CS rises after 5 bits -> frame_err pulses; rx_valid unchanged; state IDLE. Next full frame 0x5A is received correctly.
REQ-033 DATA_W=16, MSB_FIRST=0, tx 0x1234 -> first MISO bit equals tx bit 0; rx word matches master's LSB-first 0xBEEF. Reset=0 mid-frame -> all outputs at reset values within 0 clk.
